// File: rtl/keypad_pkg.sv
// Shared types, command encodings and key classification for the keypad front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StIssue,
    StRelease
  } kp_state_t;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_SHIFT = 2'b01;
  localparam logic [1:0] CTRL_BKSP  = 2'b10;
  localparam logic [1:0] CTRL_CLR   = 2'b11;

  typedef enum logic [1:0] {
    KeyDigit,
    KeyBksp,
    KeyClr,
    KeyOp
  } key_class_t;

  typedef struct packed {
    key_class_t cls;
    logic [3:0] val;
  } key_info_t;

  // val carries the digit for digits and the operator index for operators.
  function automatic key_info_t classify_key(input logic [3:0] k);
    key_info_t r;
    if (k <= 4'd9) begin
      r.cls = KeyDigit;
      r.val = k;
    end else if (k == 4'd10) begin
      r.cls = KeyBksp;
      r.val = 4'd0;
    end else if (k == 4'd11) begin
      r.cls = KeyClr;
      r.val = 4'd0;
    end else begin
      r.cls = KeyOp;
      r.val = k - 4'd12;
    end
    return r;
  endfunction

  function automatic logic [1:0] ctrl_of(input key_class_t c);
    logic [1:0] r;
    unique case (c)
      KeyDigit: r = CTRL_SHIFT;
      KeyBksp:  r = CTRL_BKSP;
      KeyClr:   r = CTRL_CLR;
      default:  r = CTRL_HOLD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_row_sync.sv
// Two-flop synchronizer for the raw row sense lines; resets to all-ones (no key).
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Matrix keypad scanner/debouncer issuing one command per press to the digit array.
// Optional auto-repeat of held digit keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 1024
`endif
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  input  logic             rdy,
  output logic [1:0]       ctrl,
  output logic [WIDTH-1:0] shift_in,
  output logic             op_valid,
  output logic [1:0]       op_code,
  output logic             busy
);

  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SCW = $clog2(SCAN_CYCLES);
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  kp_state_t         state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ROWS-1:0]   pat_q;
  logic [SCW-1:0]    scan_cnt_q;
  logic [DCW-1:0]    deb_cnt_q;

  logic [ROWS-1:0]   rows_s;
  logic              any_low;
  logic [RW-1:0]     low_row;
  logic [CW-1:0]     next_col;
  logic [3:0]        key_idx;
  key_info_t         key;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RPW-1:0] rep_cnt_q;
`endif

  row_sync #(
    .WIDTH (ROWS)
  ) u_row_sync (
    .clk  (clk),
    .srst (srst),
    .d    (row_n),
    .q    (rows_s)
  );

  function automatic logic [COLS-1:0] drive_col(input logic [CW-1:0] c);
    logic [COLS-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return ~(one << c);
  endfunction

  assign any_low  = ~&rows_s;
  assign next_col = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
  assign key_idx  = 4'((32'(row_q) * COLS) + 32'(col_q));
  assign key      = classify_key(key_idx);

  // Descending scan so the lowest-index low row is the one that sticks.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows_s[i]) low_row = RW'(i);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q    <= StScan;
      col_q      <= '0;
      row_q      <= '0;
      pat_q      <= '1;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_n      <= '1;
      ctrl       <= CTRL_HOLD;
      shift_in   <= '0;
      op_valid   <= 1'b0;
      op_code    <= '0;
      busy       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StScan: begin
          if (col_n == '1) begin
            // First cycle out of reset: start driving the current column.
            col_n      <= drive_col(col_q);
            scan_cnt_q <= '0;
          end else if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
            scan_cnt_q <= '0;
            if (any_low) begin
              pat_q     <= rows_s;
              row_q     <= low_row;
              deb_cnt_q <= '0;
              state_q   <= StDebounce;
              busy      <= 1'b1;
            end else begin
              col_q <= next_col;
              col_n <= drive_col(next_col);
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
          end
        end

        StDebounce: begin
          if (deb_cnt_q == DCW'(DEBOUNCE_CYCLES)) begin
            state_q <= StIssue;
            if (key.cls == KeyOp) begin
              op_valid <= 1'b1;
              op_code  <= key.val[1:0];
            end else begin
              ctrl     <= ctrl_of(key.cls);
              shift_in <= (key.cls == KeyDigit) ? WIDTH'(key.val) : '0;
            end
          end else if (rows_s != pat_q) begin
            state_q    <= StScan;
            busy       <= 1'b0;
            col_q      <= next_col;
            col_n      <= drive_col(next_col);
            scan_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
          end
        end

        StIssue: begin
          if (op_valid) begin
            op_valid  <= 1'b0;
            state_q   <= StRelease;
            deb_cnt_q <= '0;
          end else if (rdy) begin
            ctrl      <= CTRL_HOLD;
            state_q   <= StRelease;
            deb_cnt_q <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
          end
        end

        StRelease: begin
          if (any_low) begin
            deb_cnt_q <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rows_s == pat_q && key.cls == KeyDigit) begin
              if (rep_cnt_q == RPW'(REPEAT_CYCLES - 1)) begin
                // shift_in still holds this key's digit from the first issue.
                rep_cnt_q <= '0;
                ctrl      <= CTRL_SHIFT;
                state_q   <= StIssue;
              end else begin
                rep_cnt_q <= rep_cnt_q + RPW'(1);
              end
            end else begin
              rep_cnt_q <= '0;
            end
`endif
          end else if (deb_cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
            state_q    <= StScan;
            busy       <= 1'b0;
            col_q      <= next_col;
            col_n      <= drive_col(next_col);
            scan_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
          end
        end

        default: state_q <= StScan;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: keypad matrix model, directed sequences, random presses.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       rdy = 1'b0;
  logic [1:0] ctrl;
  logic [3:0] shift_in;
  logic       op_valid;
  logic [1:0] op_code;
  logic       busy;

  logic [15:0] pressed = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;  // 0 command transfer, 1 operator pulse
    int code;  // ctrl or op_code
    int val;   // shift_in for commands
  } ev_t;

  typedef struct {
    int  key;
    int  rdy_delay;
    int  hold;
    ev_t exp;
  } vec_t;

  ev_t  log_q[$];
  vec_t tbl[$];

  keypad_entry dut (
    .clk      (clk),
    .srst     (srst),
    .row_n    (row_n),
    .col_n    (col_n),
    .rdy      (rdy),
    .ctrl     (ctrl),
    .shift_in (shift_in),
    .op_valid (op_valid),
    .op_code  (op_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key shorts its row to its column drive.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: what one clean press of key k must produce.
  function automatic ev_t ref_event(input int k);
    ev_t e;
    e.val = 0;
    if (k < 10) begin
      e.kind = 0; e.code = 1; e.val = k;
    end else if (k == 10) begin
      e.kind = 0; e.code = 2;
    end else if (k == 11) begin
      e.kind = 0; e.code = 3;
    end else begin
      e.kind = 1; e.code = k - 12;
    end
    return e;
  endfunction

  // Monitor: logs transfers/pulses and checks hold-stability and one-cycle shapes.
  bit prev_wait = 0, prev_xfer = 0, prev_op = 0;
  logic [1:0] prev_ctrl;
  logic [3:0] prev_shift;
  always @(negedge clk) begin
    if (srst) begin
      prev_wait = 0; prev_xfer = 0; prev_op = 0;
    end else begin
      if (prev_xfer) check("ctrl_idle_after_xfer", ctrl, 0);
      if (prev_wait) begin
        check("ctrl_held_stable", ctrl, prev_ctrl);
        check("shift_in_held_stable", shift_in, prev_shift);
      end
      if (prev_op) check("op_valid_single_pulse", op_valid, 0);
      if (op_valid) check("ctrl_idle_during_op", ctrl, 0);
      if (ctrl != 2'b00 && rdy) log_q.push_back('{kind: 0, code: int'(ctrl), val: int'(shift_in)});
      if (op_valid) log_q.push_back('{kind: 1, code: int'(op_code), val: 0});
      prev_xfer  = (ctrl != 2'b00) && rdy;
      prev_wait  = (ctrl != 2'b00) && !rdy;
      prev_op    = op_valid;
      prev_ctrl  = ctrl;
      prev_shift = shift_in;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input ev_t exp);
    check({tag, "_count"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      check({tag, "_kind"}, log_q[0].kind, exp.kind);
      check({tag, "_code"}, log_q[0].code, exp.code);
      if (exp.kind == 0 && exp.code == 1) check({tag, "_digit"}, log_q[0].val, exp.val);
    end
  endtask

  task automatic run_press(input int keys, input int rdy_delay, input int hold, input ev_t exp,
                           input string tag);
    bit seen = 0;
    log_q.delete();
    rdy = (rdy_delay == 0);
    pressed = 16'(keys);
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (ctrl != 2'b00 || op_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_accepted"}, int'(seen), 1);
    if (seen && ctrl != 2'b00 && rdy_delay > 0) begin
      step(rdy_delay);
      check({tag, "_ctrl_before_rdy"}, ctrl, exp.code);
      rdy = 1'b1;
    end
    step(hold + 5);
    pressed = '0;
    step(80);
    check_log(tag, exp);
  endtask

  task automatic add_vec(input int k, input int d, input int h, input int kind, input int code,
                         input int val);
    vec_t v;
    v.key = k; v.rdy_delay = d; v.hold = h;
    v.exp.kind = kind; v.exp.code = code; v.exp.val = val;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    ev_t e;
    add_vec(7, 0, 20, 0, 1, 7);
    add_vec(3, 50, 10, 0, 1, 3);
    add_vec(12, 0, 10, 1, 0, 0);
    add_vec(11, 0, 10, 0, 3, 0);
    add_vec(10, 2, 10, 0, 2, 0);
    add_vec(15, 0, 10, 1, 3, 0);
    add_vec(9, 1, 40, 0, 1, 9);

    // Reset values, with key 0 already held so the first sample catches it.
    pressed = 16'h0001;
    step(3);
    check("reset_col_n", col_n, 4'hf);
    check("reset_ctrl", ctrl, 0);
    check("reset_shift_in", shift_in, 0);
    check("reset_op_valid", op_valid, 0);
    check("reset_op_code", op_code, 0);
    check("reset_busy", busy, 0);

    // Column 0 driven on edge 1, sampled on edge 5, ctrl set on edge 5+16+1.
    @(negedge clk);
    srst = 1'b0;
    log_q.delete();
    step(1);
    check("first_col_driven", col_n, 4'he);
    step(3);
    check("busy_before_sample", busy, 0);
    step(1);
    check("busy_at_sample", busy, 1);
    step(16);
    check("ctrl_before_latency", ctrl, 0);
    step(1);
    check("ctrl_at_latency", ctrl, 1);
    check("shift_in_at_latency", shift_in, 0);
    rdy = 1'b1;
    step(10);
    pressed = '0;
    step(80);
    e = ref_event(0);
    check_log("first_press", e);

    foreach (tbl[i]) run_press(1 << tbl[i].key, tbl[i].rdy_delay, tbl[i].hold, tbl[i].exp,
                               $sformatf("vec%0d", i));

    // Bounce: key 5 toggling every 5 cycles never survives debounce.
    log_q.delete();
    for (int i = 0; i < 12; i++) begin
      pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      step(5);
    end
    pressed = '0;
    step(30);
    check("bounce_no_command", log_q.size(), 0);
    e = ref_event(5);
    run_press(1 << 5, 0, 10, e, "after_bounce");

    // Rows 0 and 2 low on column 1: lowest row wins.
    e = ref_event(1);
    run_press((1 << 1) | (1 << 9), 0, 10, e, "multi_row");

    // Reset during ISSUE drops the pending command.
    log_q.delete();
    rdy = 1'b0;
    pressed = 16'h0010;
    begin
      bit seen = 0;
      for (int i = 0; i < 300; i++) begin
        step(1);
        if (ctrl != 2'b00) begin
          seen = 1;
          break;
        end
      end
      check("rst_issue_reached", int'(seen), 1);
    end
    #2;
    srst = 1'b1;
    #1;
    check("rst_ctrl_immediate", ctrl, 0);
    check("rst_busy_immediate", busy, 0);
    check("rst_col_n_immediate", col_n, 4'hf);
    rdy = 1'b1;
    pressed = '0;
    step(3);
    @(negedge clk);
    srst = 1'b0;
    step(100);
    check("rst_command_dropped", log_q.size(), 0);

    // Random presses against the reference model.
    for (int i = 0; i < 20; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      e = ref_event(k);
      run_press(1 << k, int'($urandom_range(0, 6)), int'($urandom_range(0, 30)), e,
                $sformatf("rand%0d_k%0d", i, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Matrix-keypad front end that scans a ROWS×COLS switch matrix, debounces presses, and converts each accepted key into a one-shot command for the downstream digit shift register. It sits directly upstream of the digit array: it drives that array's `ctrl` and `shift_in` inputs and honours its `rdy` output. Operator keys are reported on a separate pulse port for the calculator core.

## Interface
- `ROWS`, 4, number of keypad rows (sense lines).
- `COLS`, 4, number of keypad columns (drive lines); ROWS*COLS must be 16.
- `WIDTH`, 4, digit width on `shift_in`; must be ≥4.
- `SCAN_CYCLES`, 4, dwell cycles per column, ≥3.
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a press or a release, ≥2.
- `clk  input  1  system clock`
- `srst  input  1  reset; asynchronous, active-high`
- `row_n  input  ROWS  raw active-low row sense lines (pulled up externally, asynchronous)`
- `col_n  output  COLS  active-low column drive, one-hot-low while scanning`
- `rdy  input  1  downstream shift register can accept a command`
- `ctrl  output  2  command: 00 hold, 01 shift digit in, 10 backspace, 11 clear`
- `shift_in  output  WIDTH  digit value, zero-extended`
- `op_valid  output  1  single-cycle pulse: operator key accepted`
- `op_code  output  2  operator index, valid with op_valid`
- `busy  output  1  high in any state other than SCAN`

## Operation
- Key index k = row*COLS + col. k 0–9 → digit k (ctrl 01, shift_in = k). k 10 → backspace (ctrl 10). k 11 → clear (ctrl 11). k 12–15 → operator, op_code = k-12, no ctrl.
- `row_n` passes through a 2-flop synchronizer before any use.
- FSM states: SCAN, DEBOUNCE, ISSUE, RELEASE.
- SCAN: drive `col_n` low on the current column for SCAN_CYCLES cycles. Sample the synchronized rows on the last dwell cycle. If any row is low, latch column and row, then enter DEBOUNCE. Otherwise advance to the next column, wrapping COLS-1 → 0.
- Several rows low at once: the lowest-index row wins.
- DEBOUNCE: hold the column. Count cycles in which the synchronized rows equal the latched pattern.
  - Any mismatch → SCAN at the next column, no output.
  - Count reaches DEBOUNCE_CYCLES → ISSUE.
- ISSUE, operator key: pulse `op_valid` for one cycle, then go to RELEASE.
- ISSUE, digit/backspace/clear: drive `ctrl`/`shift_in` and hold them stable until a posedge with `rdy`=1. That edge is the transfer. Next cycle `ctrl`=00, then go to RELEASE. If `rdy` is already high on entry, the transfer happens on the first ISSUE edge.
- RELEASE: hold the column. Require DEBOUNCE_CYCLES consecutive cycles with all rows high; any low row restarts the count. Then go to SCAN at the next column.
- At most one command is issued per physical press (unless auto-repeat is enabled).
- Asynchronous `srst` mid-operation: all outputs and state return to reset values immediately. A pending command is dropped and never issued.

## Timing
- Reset values: `col_n`='1, `ctrl`=00, `shift_in`=0, `op_valid`=0, `op_code`=0, `busy`=0. State SCAN, column 0, all counters 0.
- First column is driven on the first edge after `srst` deasserts.
- A clean press seen at a sample point reaches `ctrl` exactly DEBOUNCE_CYCLES+1 cycles after that sample edge.
- `ctrl`≠00 lasts ≥1 cycle and ends the cycle after the `rdy` transfer.
- `busy` is registered and asserts on the same edge that leaves SCAN.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - Adds parameter `REPEAT_CYCLES` (default 1024).
  - In RELEASE, a digit key held continuously for REPEAT_CYCLES re-enters ISSUE and issues the same digit again; the repeat timer restarts after each issue.
  - Backspace, clear and operator keys never repeat.
- Not defined: no repeat logic; one command per press.

## Structure
- Package `keypad_pkg`:
  - state enum `kp_state_t`
  - ctrl constants `CTRL_HOLD`, `CTRL_SHIFT`, `CTRL_BKSP`, `CTRL_CLR`
  - key-class enum (DIGIT, BKSP, CLR, OP)
  - function `classify_key` mapping k to class and value
- Sub-module `row_sync`: parameterized ROWS-wide 2-flop synchronizer with asynchronous reset to all-ones.

## Test plan
- Press k=7 (row 1, col 3), stable 40 cycles, `rdy`=1 → one cycle `ctrl`=01, `shift_in`=7; then `ctrl`=00; no second command until release plus re-press.
- Press k=3 with `rdy`=0 for 50 cycles, then `rdy`=1 → `ctrl`=01/`shift_in`=3 held all 50 cycles; transfer on the first `rdy` edge; `ctrl`=00 the next cycle.
- Bounce: k=5 toggling every 5 cycles for 60 cycles with DEBOUNCE_CYCLES=16 → no command; then stable → exactly one `ctrl`=01, `shift_in`=5.
- Keys k=12 and k=11 pressed in turn → `op_valid` pulse with `op_code`=0 and `ctrl` stays 00; then `ctrl`=11.
- Rows 0 and 2 low on col 1 → k=1 is issued. `srst` asserted during ISSUE → `ctrl`=00 immediately and the command is never issued after reset.
- With `KEYPAD_AUTOREPEAT_EN`, REPEAT_CYCLES=100: hold k=9 for 350 cycles after acceptance → 4 commands with `shift_in`=9.
